// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit.
//   - ALU control encodings (only MULc and DIVc matter to the MDU)
//   - HI/LO source-select encodings
//   - FSM state and latched-operation enums
//   - default operand width
package mdu_pkg;

  localparam int MDU_WIDTH = 32;

  localparam logic [2:0] ADDc = 3'b000;
  localparam logic [2:0] SUBc = 3'b001;
  localparam logic [2:0] MULc = 3'b010;
  localparam logic [2:0] DIVc = 3'b011;
  localparam logic [2:0] ANDc = 3'b100;
  localparam logic [2:0] ORc  = 3'b101;

  localparam logic [1:0] SEL_RES = 2'b00;
  localparam logic [1:0] SEL_RS  = 2'b01;
  localparam logic [1:0] SEL_ACC = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MULT = 2'b01,
    S_DIV  = 2'b10,
    S_DONE = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_MADD = 2'b01,
    OP_MSUB = 2'b10,
    OP_DIV  = 2'b11
  } op_e;

endpackage

// File: rtl/mdu_iter_core.sv
// Unsigned iterative datapath shared by multiply and divide.
//   Multiply: radix-2 shift-add, {upper,lower} ends as the 2*WIDTH product.
//   Divide:   restoring, upper ends as remainder, lower as quotient.
// Ports:
//   clk, rst   clock, async active-high reset
//   load       latch a/b and start WIDTH iterations
//   is_div     select divide (1) or multiply (0) for the loaded op
//   a, b       unsigned magnitudes (multiplicand/multiplier, dividend/divisor)
//   step_done  high in the cycle whose closing edge performs the last step
//   result     value the registers take at that edge: {upper, lower}
module mdu_iter_core
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 is_div,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 step_done,
  output logic [2*WIDTH-1:0]   result
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] upper;
  logic [WIDTH-1:0] lower;
  logic [WIDTH-1:0] divisor;
  logic [CW-1:0]    count;
  logic             active;
  logic             div_mode;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] upper_next;
  logic [WIDTH-1:0] lower_next;

  // NOTE: every always_comb output gets a value on every path; a path that
  // leaves one unassigned turns it into a latch.
  always_comb begin
    // Multiply: add the multiplicand when the current multiplier bit is set,
    // then shift the (WIDTH+1)-bit sum and the multiplier right together.
    sum   = {1'b0, upper} + (lower[0] ? {1'b0, divisor} : '0);
    // Divide: shift the next dividend bit into the partial remainder and
    // try subtracting; a set sign bit means the divisor did not fit.
    trial = {upper, lower[WIDTH-1]};
    diff  = trial - {1'b0, divisor};
    if (div_mode) begin
      upper_next = diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
      lower_next = {lower[WIDTH-2:0], ~diff[WIDTH]};
    end else begin
      upper_next = sum[WIDTH:1];
      lower_next = {sum[0], lower[WIDTH-1:1]};
    end
  end

  assign result    = {upper_next, lower_next};
  assign step_done = active && (count == CW'(WIDTH - 1));

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      upper    <= '0;
      lower    <= '0;
      divisor  <= '0;
      count    <= '0;
      active   <= 1'b0;
      div_mode <= 1'b0;
    end else if (load) begin
      upper    <= '0;
      lower    <= a;
      divisor  <= b;
      count    <= '0;
      active   <= 1'b1;
      div_mode <= is_div;
    end else if (active) begin
      upper  <= upper_next;
      lower  <= lower_next;
      count  <= step_done ? '0 : count + 1'b1;
      active <= !step_done;
    end
  end

endmodule

// File: rtl/hilo_mdu.sv
// HI/LO multiply/divide unit: MUL, MADD, MSUB, DIV (multi-cycle) and
// MTHI, MTLO (single-cycle writes). Owns the FSM, sign handling, the
// accumulate path and the HI/LO registers.
// Ports:
//   clk, rst                  clock, async active-high reset
//   start                     issue strobe, honoured only while busy=0
//   aluCtrl, hiSel, loSel     decoded control from the control unit
//   hiWr, loWr, maluOp        write enables, MADD(1)/MSUB(0) select
//   rs_data, rt_data          signed operands; rs_data also feeds MTHI/MTLO
//   busy                      iterative op in progress
//   done                      one-cycle pulse, hi/lo already updated
//   div_by_zero               pulses with done for a DIV by zero
//   hi, lo                    architectural HI/LO registers
module hilo_mdu
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       aluCtrl,
  input  logic [1:0]       hiSel,
  input  logic [1:0]       loSel,
  input  logic             hiWr,
  input  logic             loWr,
  input  logic             maluOp,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_e state;
  state_e state_next;
  op_e    op;

  logic             sign_a;
  logic             sign_b;
  logic             b_zero;
  logic [WIDTH-1:0] rs_hold;

  logic accept;
  logic do_mul;
  logic do_acc;
  logic do_div;
  logic do_mthi;
  logic do_mtlo;
  logic load;

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic               step_done;
  logic [2*WIDTH-1:0] core_result;

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   hi_final;
  logic [WIDTH-1:0]   lo_final;

  assign busy        = (state == S_MULT) || (state == S_DIV);
  assign done        = (state == S_DONE);
  assign div_by_zero = done && (op == OP_DIV) && b_zero;

  assign accept  = start && !busy;
  assign do_mul  = hiWr && loWr && (aluCtrl == MULc) && (hiSel == SEL_RES);
  assign do_acc  = hiWr && loWr && (aluCtrl == MULc) && (hiSel == SEL_ACC);
  assign do_div  = hiWr && loWr && (aluCtrl == DIVc);
  assign do_mthi = hiWr && !loWr && (hiSel == SEL_RS);
  assign do_mtlo = loWr && !hiWr && (loSel == SEL_RS);
  assign load    = accept && (do_mul || do_acc || do_div);

  // Magnitudes are unsigned, so -2^(W-1) maps cleanly to 2^(W-1).
  assign a_mag = rs_data[WIDTH-1] ? -rs_data : rs_data;
  assign b_mag = rt_data[WIDTH-1] ? -rt_data : rt_data;

  mdu_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .is_div    (do_div),
    .a         (a_mag),
    .b         (b_mag),
    .step_done (step_done),
    .result    (core_result)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE: begin
        state_next = S_IDLE;
        if (accept && (do_mul || do_acc)) state_next = S_MULT;
        else if (accept && do_div)        state_next = S_DIV;
      end
      S_MULT, S_DIV: if (step_done) state_next = S_DONE;
      default:       state_next = S_IDLE;
    endcase
  end

  // Signs are kept alongside the magnitudes so the result can be fixed up
  // in the same edge the last iteration completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op      <= OP_MUL;
      sign_a  <= 1'b0;
      sign_b  <= 1'b0;
      b_zero  <= 1'b0;
      rs_hold <= '0;
    end else if (load) begin
      op      <= do_div ? OP_DIV : (do_acc ? (maluOp ? OP_MADD : OP_MSUB) : OP_MUL);
      sign_a  <= rs_data[WIDTH-1];
      sign_b  <= rt_data[WIDTH-1];
      b_zero  <= (rt_data == '0);
      rs_hold <= rs_data;
    end
  end

  // Quotient is negative when signs differ; remainder follows the dividend.
  always_comb begin
    prod     = (sign_a ^ sign_b) ? -core_result : core_result;
    quot     = (sign_a ^ sign_b) ? -core_result[WIDTH-1:0] : core_result[WIDTH-1:0];
    rem      = sign_a ? -core_result[2*WIDTH-1:WIDTH] : core_result[2*WIDTH-1:WIDTH];
    hi_final = hi;
    lo_final = lo;
    case (op)
      OP_MUL:  {hi_final, lo_final} = prod;
      OP_MADD: {hi_final, lo_final} = {hi, lo} + prod;
      OP_MSUB: {hi_final, lo_final} = {hi, lo} - prod;
      OP_DIV: begin
        if (b_zero) begin
          hi_final = rs_hold;
          lo_final = '1;
        end else begin
          hi_final = rem;
          lo_final = quot;
        end
      end
      default: ;
    endcase
  end

  // accept implies !busy, so the issue-edge writes and the final-iteration
  // write can never collide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else if (accept && do_mthi) begin
      hi <= rs_data;
    end else if (accept && do_mtlo) begin
      lo <= rs_data;
    end else if (busy && step_done) begin
      hi <= hi_final;
      lo <= lo_final;
    end
  end

endmodule

// File: tb/tb_hilo_mdu.sv
module tb_hilo_mdu;
  import mdu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   aluCtrl = 3'b000;
  logic [1:0]   hiSel = 2'b00;
  logic [1:0]   loSel = 2'b00;
  logic         hiWr = 1'b0;
  logic         loWr = 1'b0;
  logic         maluOp = 1'b0;
  logic [W-1:0] rs_data = '0;
  logic [W-1:0] rt_data = '0;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  always #5 clk = ~clk;

  hilo_mdu #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .aluCtrl     (aluCtrl),
    .hiSel       (hiSel),
    .loSel       (loSel),
    .hiWr        (hiWr),
    .loWr        (loWr),
    .maluOp      (maluOp),
    .rs_data     (rs_data),
    .rt_data     (rt_data),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  typedef enum int {K_MUL, K_MADD, K_MSUB, K_DIV, K_MTHI, K_MTLO, K_NOP} kind_e;

  typedef struct {
    kind_e       kind;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    logic        exp_dbz;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Called at a negedge; the following posedge is the issue edge, and the
  // task returns at the negedge after it.
  task automatic issue(input kind_e k, input logic [31:0] a, input logic [31:0] b);
    rs_data = a;
    rt_data = b;
    aluCtrl = ADDc;
    hiSel   = SEL_RES;
    loSel   = SEL_RES;
    hiWr    = 1'b0;
    loWr    = 1'b0;
    maluOp  = 1'b0;
    case (k)
      K_MUL:  begin aluCtrl = MULc; hiWr = 1'b1; loWr = 1'b1; end
      K_MADD: begin aluCtrl = MULc; hiSel = SEL_ACC; loSel = SEL_ACC; hiWr = 1'b1; loWr = 1'b1; maluOp = 1'b1; end
      K_MSUB: begin aluCtrl = MULc; hiSel = SEL_ACC; loSel = SEL_ACC; hiWr = 1'b1; loWr = 1'b1; maluOp = 1'b0; end
      K_DIV:  begin aluCtrl = DIVc; hiWr = 1'b1; loWr = 1'b1; end
      K_MTHI: begin hiSel = SEL_RS; hiWr = 1'b1; end
      K_MTLO: begin loSel = SEL_RS; loWr = 1'b1; end
      default: begin aluCtrl = ADDc; hiWr = 1'b1; loWr = 1'b1; end
    endcase
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts busy cycles (bounded), then compares the result against the
  // oldest scoreboard entry. Returns at the negedge where done should be high.
  task automatic wait_op(input string name, input int expected_busy);
    int   n;
    exp_t e;
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (expected_busy > 0) check($sformatf("%s busy_cycles", name), 64'(n), 64'(expected_busy));
    check($sformatf("%s done", name), {63'd0, done}, 64'd1);
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s scoreboard: got empty expected an entry", name);
    end else begin
      e = sb.pop_front();
      check($sformatf("%s hi", name), {32'd0, hi}, {32'd0, e.hi});
      check($sformatf("%s lo", name), {32'd0, lo}, {32'd0, e.lo});
      check($sformatf("%s div_by_zero", name), {63'd0, div_by_zero}, {63'd0, e.dbz});
    end
  endtask

  function automatic exp_t model(input kind_e k, input logic [31:0] a, input logic [31:0] b,
                                 input logic [63:0] acc);
    exp_t   e;
    longint p;
    int     q;
    int     r;
    p = longint'($signed(a)) * longint'($signed(b));
    e.dbz = 1'b0;
    {e.hi, e.lo} = acc;
    case (k)
      K_MUL:  {e.hi, e.lo} = p;
      K_MADD: {e.hi, e.lo} = acc + p;
      K_MSUB: {e.hi, e.lo} = acc - p;
      K_DIV: begin
        if (b == 32'd0) begin
          e.hi = a; e.lo = 32'hFFFF_FFFF; e.dbz = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          e.hi = 32'd0; e.lo = 32'h8000_0000;
        end else begin
          q = $signed(a) / $signed(b);
          r = $signed(a) % $signed(b);
          e.hi = r; e.lo = q;
        end
      end
      default: ;
    endcase
    return e;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[13];
    vec_t        v;
    exp_t        e;
    logic [63:0] m_acc;
    kind_e       rk;
    logic [31:0] ra;
    logic [31:0] rb;
    int          pulses;

    tbl[0]  = '{K_MUL,  32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
    tbl[1]  = '{K_MTHI, 32'd0,         32'd0,        32'd0,         32'hFFFF_FFEB, 1'b0};
    tbl[2]  = '{K_MTLO, 32'd10,        32'd0,        32'd0,         32'd10,        1'b0};
    tbl[3]  = '{K_MADD, 32'd4,         32'd5,        32'd0,         32'd30,        1'b0};
    tbl[4]  = '{K_MSUB, 32'd2,         32'd20,       32'hFFFF_FFFF, 32'hFFFF_FFF6, 1'b0};
    tbl[5]  = '{K_DIV,  32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    tbl[6]  = '{K_DIV,  32'd5,         32'd0,        32'd5,         32'hFFFF_FFFF, 1'b1};
    tbl[7]  = '{K_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, 1'b0};
    tbl[8]  = '{K_DIV,  32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD, 1'b0};
    tbl[9]  = '{K_MUL,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,        1'b0};
    tbl[10] = '{K_NOP,  32'd99,        32'd1,        32'h4000_0000, 32'd0,         1'b0};
    tbl[11] = '{K_MUL,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,        32'd1,         1'b0};
    tbl[12] = '{K_DIV,  32'd100,       32'd7,        32'd2,         32'd14,        1'b0};

    // Reset release and reset after register writes.
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset hi", {32'd0, hi}, 64'd0);
    check("reset lo", {32'd0, lo}, 64'd0);
    check("reset flags", {61'd0, busy, done, div_by_zero}, 64'd0);

    issue(K_MTHI, 32'h55, 32'd0);
    issue(K_MTLO, 32'hAA, 32'd0);
    check("mthi value", {32'd0, hi}, 64'h55);
    check("mtlo value", {32'd0, lo}, 64'hAA);
    #2 rst = 1'b1;
    #1;
    check("async reset hi", {32'd0, hi}, 64'd0);
    check("async reset lo", {32'd0, lo}, 64'd0);
    check("async reset flags", {61'd0, busy, done, div_by_zero}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven vectors.
    m_acc = 64'd0;
    for (int i = 0; i < 13; i++) begin
      v = tbl[i];
      issue(v.kind, v.rs, v.rt);
      if (v.kind inside {K_MUL, K_MADD, K_MSUB, K_DIV}) begin
        sb.push_back('{v.exp_hi, v.exp_lo, v.exp_dbz});
        wait_op($sformatf("vec%0d", i), W);
        @(negedge clk);
        check($sformatf("vec%0d done_drop", i), {62'd0, done, div_by_zero}, 64'd0);
      end else begin
        check($sformatf("vec%0d no_busy", i), {62'd0, busy, done}, 64'd0);
        check($sformatf("vec%0d hi", i), {32'd0, hi}, {32'd0, v.exp_hi});
        check($sformatf("vec%0d lo", i), {32'd0, lo}, {32'd0, v.exp_lo});
      end
      m_acc = {v.exp_hi, v.exp_lo};
    end

    // Randomised ops against the arithmetic model.
    for (int j = 0; j < 8; j++) begin
      rk = kind_e'(j % 4);
      ra = $urandom;
      rb = (rk == K_DIV) ? (($urandom_range(0, 1) == 1) ? -32'($urandom_range(1, 1000))
                                                         : 32'($urandom_range(1, 1000)))
                         : $urandom;
      e = model(rk, ra, rb, m_acc);
      sb.push_back(e);
      issue(rk, ra, rb);
      wait_op($sformatf("rand%0d", j), W);
      m_acc = {e.hi, e.lo};
      @(negedge clk);
    end

    // Stray MTHI strobe during a MUL is ignored.
    e = model(K_MUL, 32'd5, 32'd6, m_acc);
    sb.push_back(e);
    issue(K_MUL, 32'd5, 32'd6);
    repeat (5) @(negedge clk);
    issue(K_MTHI, 32'h1234, 32'd0);
    check("stray mthi hi", {32'd0, hi}, {32'd0, m_acc[63:32]});
    check("stray mthi busy", {63'd0, busy}, 64'd1);
    wait_op("stray mul", 0);
    m_acc = {e.hi, e.lo};

    // Back-to-back MADD issued in DONE sees the just-written hi/lo.
    e = model(K_MADD, 32'd3, 32'hFFFF_FFFC, m_acc);
    sb.push_back(e);
    issue(K_MADD, 32'd3, 32'hFFFF_FFFC);
    check("b2b no_bubble", {63'd0, busy}, 64'd1);
    wait_op("b2b madd", W);
    @(negedge clk);
    check("b2b done_drop", {63'd0, done}, 64'd0);

    // Reset at cycle 10 of a MUL aborts it with no done.
    issue(K_MUL, 32'd9, 32'd9);
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort busy", {63'd0, busy}, 64'd0);
    check("abort hi", {32'd0, hi}, 64'd0);
    check("abort lo", {32'd0, lo}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    check("abort no_done", 64'(pulses), 64'd0);
    check("abort hilo_after", {hi, lo}, 64'd0);
    check("scoreboard drained", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
